// File: rtl/gsdiv_pkg.sv
// Shared types and width helpers for the sequential Goldschmidt divider.
// The optional GSDIV_SIGNED_EN build is handled in goldschmidt_div_seq.
package gsdiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NORM = 3'd1,
    ITER = 3'd2,
    CORR = 3'd3,
    DONE = 3'd4
  } gsdiv_state_e;

  localparam int GSDIV_GUARD = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Fractional bits of the internal N/D registers: two operand widths plus guard.
  function automatic int frac_w(input int width, input int guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/gsdiv_normalize.sv
// Leading-one detect on the divisor plus the left shift that puts its MSB at
// the top bit. A zero divisor produces a zero result (handled by the caller).
module gsdiv_normalize
  import gsdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_d_norm,
  output logic [SW-1:0]    o_shift
);

  logic [SW-1:0] w_lead;

  always_comb begin
    w_lead = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_d[i]) w_lead = SW'(i);
    end
    o_shift  = SW'(WIDTH - 1) - w_lead;
    o_d_norm = i_d << o_shift;
  end

endmodule

// File: rtl/goldschmidt_div_seq.sv
// Sequential Goldschmidt divider: floor(n * 2^WIDTH / d) as q.f, one op in flight.
// Define GSDIV_SIGNED_EN to treat n and d as two's complement.
module goldschmidt_div_seq
  import gsdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 7,
  parameter int GUARD = GSDIV_GUARD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] f,
  output logic             dz,
  output logic [2:0]       o_dbg_state
);

  localparam int FW = frac_w(WIDTH, GUARD);
  localparam int NW = WIDTH + FW;
  localparam int SW = clog2(WIDTH);
  localparam int CW = clog2(ITERS + 1);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; a producer holding valid keeps its data stable until that edge.
  gsdiv_state_e r_state, w_next;
  logic w_accept;
  logic [WIDTH-1:0] w_n_mag, w_d_mag;
  logic w_neg;

  logic [WIDTH-1:0] r_n_in, r_d_in;
  logic             r_neg;
  logic [NW-1:0]    r_nn;
  logic [FW-1:0]    r_dd;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q, r_f;
  logic             r_dz;

  logic [WIDTH-1:0]     w_d_norm;
  logic [SW-1:0]        w_shift;
  logic [NW-1:0]        w_n_ext, w_n_norm, w_n_next;
  logic [FW:0]          w_f;
  logic [NW+FW:0]       w_nprod;
  logic [2*FW:0]        w_dprod;
  logic [FW-1:0]        w_d_next;
  logic [2*WIDTH-1:0]   w_c, w_corr, w_res;
  logic [3*WIDTH-1:0]   w_p, w_r, w_rem;

`ifdef GSDIV_SIGNED_EN
  logic [WIDTH:0] w_n_wide, w_d_wide;
  // Widen by one bit so the most-negative operand's magnitude is representable.
  assign w_n_wide = n[WIDTH-1] ? -{1'b1, n} : {1'b0, n};
  assign w_d_wide = d[WIDTH-1] ? -{1'b1, d} : {1'b0, d};
  assign w_n_mag  = WIDTH'(w_n_wide);
  assign w_d_mag  = WIDTH'(w_d_wide);
  assign w_neg    = n[WIDTH-1] ^ d[WIDTH-1];
`else
  assign w_n_mag  = n;
  assign w_d_mag  = d;
  assign w_neg    = 1'b0;
`endif

  gsdiv_normalize #(.WIDTH(WIDTH), .SW(SW)) u_norm (
    .i_d      (r_d_in),
    .o_d_norm (w_d_norm),
    .o_shift  (w_shift)
  );

  assign w_accept = in_valid & in_ready;

  // N and D are scaled by the same power of two, so N/D is already n/d.
  assign w_n_ext  = {{(NW-WIDTH){1'b0}}, r_n_in};
  assign w_n_norm = (w_n_ext << w_shift) << (FW - WIDTH);

  // F = 2 - D = 1 + (1 - D); D is never zero while iterating.
  assign w_f      = {1'b1, ~r_dd + FW'(1)};
  assign w_nprod  = {{(FW+1){1'b0}}, r_nn} * {{NW{1'b0}}, w_f};
  assign w_dprod  = {{(FW+1){1'b0}}, r_dd} * {{FW{1'b0}}, w_f};
  assign w_n_next = NW'(w_nprod >> FW);
  assign w_d_next = FW'(w_dprod >> FW);

  assign w_c   = (2*WIDTH)'(r_nn >> (FW - WIDTH));
  assign w_p   = {{WIDTH{1'b0}}, w_c} * {{(2*WIDTH){1'b0}}, r_d_in};
  assign w_r   = {{WIDTH{1'b0}}, r_n_in, {WIDTH{1'b0}}};
  assign w_rem = w_r - w_p;

  always_comb begin
    w_corr = w_c;
    if (w_p > w_r)
      w_corr = w_c - (2*WIDTH)'(1);
    else if (w_rem >= {{(2*WIDTH){1'b0}}, r_d_in})
      w_corr = w_c + (2*WIDTH)'(1);
  end

  assign w_res = r_neg ? (~w_corr + (2*WIDTH)'(1)) : w_corr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = NORM;
      NORM:    w_next = (r_d_in == '0) ? DONE : ITER;
      ITER:    if (r_cnt == CW'(ITERS - 1)) w_next = CORR;
      CORR:    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == IDLE);
    out_valid   = (r_state == DONE);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_in <= '0;
      r_d_in <= '0;
      r_neg  <= 1'b0;
      r_nn   <= '0;
      r_dd   <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_f    <= '0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_n_in <= w_n_mag;
          r_d_in <= w_d_mag;
          r_neg  <= w_neg;
        end
        NORM: begin
          r_nn  <= w_n_norm;
          r_dd  <= {w_d_norm, {(FW-WIDTH){1'b0}}};
          r_cnt <= '0;
          if (r_d_in == '0) begin
            r_q  <= '1;
            r_f  <= '1;
            r_dz <= 1'b1;
          end
        end
        ITER: begin
          r_nn  <= w_n_next;
          r_dd  <= w_d_next;
          r_cnt <= r_cnt + CW'(1);
        end
        CORR: begin
          {r_q, r_f} <= w_res;
          r_dz       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign q  = r_q;
  assign f  = r_f;
  assign dz = r_dz;

endmodule

// File: tb/tb_goldschmidt_div_seq.sv
// Bench for goldschmidt_div_seq: directed cases, handshake/reset scenarios and
// randomized operands against an exact floor(n * 2^32 / d) reference.
`timescale 1ns/1ps
module tb_goldschmidt_div_seq;

  localparam int W      = 32;
  localparam int ITERS  = 7;
  localparam int LAT    = ITERS + 3;
  localparam int LAT_DZ = 2;
  localparam int PERIOD = ITERS + 4;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, dz;
  logic [W-1:0] tb_n, tb_d, q, f;
  logic [2:0]   dbg_state;
  int           total, bad;
  logic [2*W:0] exp_q[$];

  goldschmidt_div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .n           (tb_n),
    .d           (tb_d),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .f           (f),
    .dz          (dz),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; tb_n = '0; tb_d = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Returns {dz, q, f}.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] num, den, res;
`ifdef GSDIV_SIGNED_EN
    longint sa, sb;
    logic [63:0] ma, mb;
`endif
    if (b == '0) return {1'b1, {(2*W){1'b1}}};
`ifdef GSDIV_SIGNED_EN
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    num = ma << 32;
    den = mb;
    res = num / den;
    if ((sa < 0) != (sb < 0)) res = -res;
`else
    num = {a, 32'h0};
    den = {32'h0, b};
    res = num / den;
`endif
    return {1'b0, res};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 11))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'($urandom_range(2, 15));
      3:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
      4:       return 32'h1 << $urandom_range(0, 31);
      default: return $urandom();
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int ok);
    int t;
    t = 0;
    tb_n = a; tb_d = b; in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = int'(in_ready);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat counts edges with the accepting edge as 1.
  task automatic receive(output int lat, output logic [2*W:0] got);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    got = {dz, q, f};
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (q !== '0) begin bad++; $display("FAIL reset_q: got %h want 0", q); end
    total++; if (f !== '0) begin bad++; $display("FAIL reset_f: got %h want 0", f); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", dz); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[6], tb[6], tq[6], tf[6];
    logic [2*W:0] got;
    int ok, lat;
`ifdef GSDIV_SIGNED_EN
    ta = '{32'hFFFF_FFF9, 32'd100, 32'd9, 32'hFFFF_FFF7, 32'h8000_0000, 32'd0};
    tb = '{32'd2, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd1, 32'd5};
    tq = '{32'hFFFF_FFFC, 32'd14, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'd0};
    tf = '{32'h8000_0000, 32'd1227133513, 32'd0, 32'd0, 32'd0, 32'd0};
`else
    ta = '{32'd100, 32'd1, 32'hFFFF_FFFF, 32'd9, 32'd0, 32'd7};
    tb = '{32'd7, 32'd3, 32'd1, 32'd3, 32'd5, 32'hFFFF_FFFF};
    tq = '{32'd14, 32'd0, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0};
    tf = '{32'd1227133513, 32'd1431655765, 32'd0, 32'd0, 32'd0, 32'd7};
`endif
    for (int i = 0; i < 6; i++) begin
      send(ta[i], tb[i], ok);
      total++; if (ok != 1) begin bad++; $display("FAIL directed_accept[%0d]: got %0d want 1", i, ok); end
      receive(lat, got);
      total++; if (lat != LAT) begin bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      total++;
      if (got !== {1'b0, tq[i], tf[i]}) begin
        bad++; $display("FAIL directed_result[%0d] %h/%h: got %h want %h", i, ta[i], tb[i], got, {1'b0, tq[i], tf[i]});
      end
    end
  endtask

  task automatic test_div_zero();
    logic [2*W:0] got;
    int ok, lat;
    send(32'd5, 32'd0, ok);
    receive(lat, got);
    total++; if (lat != LAT_DZ) begin bad++; $display("FAIL dz_latency: got %0d want %0d", lat, LAT_DZ); end
    total++; if (got !== {1'b1, {(2*W){1'b1}}}) begin bad++; $display("FAIL dz_result: got %h want all ones", got); end
    send(32'd0, 32'd0, ok);
    receive(lat, got);
    total++; if (got !== {1'b1, {(2*W){1'b1}}}) begin bad++; $display("FAIL dz_zero_num: got %h want all ones", got); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] sq, sf;
    int ok, t, errs;
    send(32'd100, 32'd7, ok);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    total++; if (!out_valid) begin bad++; $display("FAIL bp_valid_timeout: got 0 want 1"); end
    sq = q; sf = f;
    total++; if ({sq, sf} !== {32'd14, 32'd1227133513}) begin bad++; $display("FAIL bp_value: got %h want %h", {sq, sf}, {32'd14, 32'd1227133513}); end
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'b0;
      in_valid  = i[0];
      tb_n = $urandom(); tb_d = $urandom();
      @(negedge clk);
      total++;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && q === sq && f === sf)) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%b r=%b %h.%h want v=1 r=0 %h.%h", i, out_valid, in_ready, q, f, sq, sf);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
    errs = 0;
    repeat (15) begin @(negedge clk); if (out_valid !== 1'b0) errs++; end
    total++; if (errs != 0) begin bad++; $display("FAIL bp_ignored_pulses: got %0d spurious cycles want 0", errs); end
  endtask

  task automatic test_reset_mid();
    logic [2*W:0] got;
    int ok, lat, errs;
    send(32'd1000, 32'd3, ok);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (!(in_ready === 1'b1 && out_valid === 1'b0 && q === '0 && f === '0 && dz === 1'b0)) begin
      bad++; $display("FAIL mid_reset_async: got r=%b v=%b q=%h f=%h dz=%b want r=1 v=0 q=0 f=0 dz=0", in_ready, out_valid, q, f, dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (12) begin @(negedge clk); if (out_valid !== 1'b0) errs++; end
    total++; if (errs != 0) begin bad++; $display("FAIL mid_reset_discard: got %0d valid cycles want 0", errs); end
    send(32'd9, 32'd3, ok);
    receive(lat, got);
    total++; if (got !== {1'b0, 32'd3, 32'd0}) begin bad++; $display("FAIL mid_reset_next: got %h want %h", got, {1'b0, 32'd3, 32'd0}); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    logic [2*W:0] exp;
    out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (in_valid && in_ready) begin
        // accept happened on the previous edge; new operands are safe now
      end
      in_valid = (c < 40);
      if (in_ready) begin tb_n = pick_operand(); tb_d = pick_operand(); if (tb_d == '0) tb_d = 32'd3; end
      if (in_valid && in_ready) begin
        acc_cyc.push_back(c);
        exp_q.push_back(ref_div(tb_n, tb_d));
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_unexpected: got %h want none", {dz, q, f}); end
        else begin
          exp = exp_q.pop_front();
          if ({dz, q, f} !== exp) begin bad++; $display("FAIL b2b_result: got %h want %h", {dz, q, f}, exp); end
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (acc_cyc.size() != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", acc_cyc.size()); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      total++;
      if (acc_cyc[i] - acc_cyc[i-1] != PERIOD) begin
        bad++; $display("FAIL b2b_period[%0d]: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], PERIOD);
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_random();
    int done_cnt, cyc;
    logic [2*W:0] exp;
    done_cnt = 0; cyc = 0;
    while (done_cnt < 1500 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      tb_n      = pick_operand();
      tb_d      = pick_operand();
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) exp_q.push_back(ref_div(tb_n, tb_d));
      if (out_valid && out_ready) begin
        total++;
        done_cnt++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rand_unexpected: got %h want none", {dz, q, f}); end
        else begin
          exp = exp_q.pop_front();
          if ({dz, q, f} !== exp) begin bad++; $display("FAIL rand_result: got %h want %h", {dz, q, f}, exp); end
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (done_cnt != 1500) begin bad++; $display("FAIL rand_timeout: got %0d results want 1500", done_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0; bad = 0;
    test_reset();
    test_directed();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
